// File: rtl/alarm_ring_ctrl_if.sv
// Alarm ring controller bus: time/button inputs in, sounder/snooze status out.
interface alarm_ring_ctrl_if;
  logic        one_second;
  logic        alarm_enable;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        stop_button;
  logic        snooze_button;
  logic        sound_alarm;
  logic        snooze_active;
  logic [1:0]  snooze_count;
  logic        alarm_missed;

  modport master (
    output one_second, alarm_enable, current_time, alarm_time,
           stop_button, snooze_button,
    input  sound_alarm, snooze_active, snooze_count, alarm_missed
  );

  modport slave (
    input  one_second, alarm_enable, current_time, alarm_time,
           stop_button, snooze_button,
    output sound_alarm, snooze_active, snooze_count, alarm_missed
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder sequencer: ring on alarm match, stop/snooze handling,
// snooze re-arm delay, snooze limit and unattended ring timeout.
module alarm_ring_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned CNT_W      = 9
) (
  input logic               clock,
  input logic               reset,
  alarm_ring_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             match_d, stop_d, snooze_d;
  logic             missed_d;
  logic             match, match_rise, stop_press, snooze_press;

  // Press and match edge detection against last-cycle samples.
  always_comb begin
    match        = bus.alarm_enable && (bus.current_time == bus.alarm_time);
    match_rise   = match & ~match_d;
    stop_press   = bus.stop_button & ~stop_d;
    snooze_press = bus.snooze_button & ~snooze_d;
  end

  // Next-state, counter and timeout-pulse logic.
  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_rise) begin
          state_d      = RINGING;
          sec_cnt_d    = '0;
          snooze_cnt_d = '0;
        end
      end
      RINGING: begin
        if (!bus.alarm_enable || stop_press) begin
          state_d = IDLE;
        end else if (snooze_press && (snooze_cnt_q < SNOOZE_MAX)) begin
          state_d      = SNOOZING;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
          sec_cnt_d    = '0;
        end else if (bus.one_second) begin
          // A snooze press at the limit is dropped, so the tick still counts.
          if (sec_cnt_q == RING_LAST) begin
            state_d  = IDLE;
            missed_d = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + CNT_W'(1);
          end
        end
      end
      SNOOZING: begin
        if (!bus.alarm_enable || stop_press) begin
          state_d = IDLE;
        end else if (bus.one_second) begin
          if (sec_cnt_q == SNOOZE_LAST) begin
            state_d   = RINGING;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = sec_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      sec_cnt_q         <= '0;
      snooze_cnt_q      <= '0;
      match_d           <= 1'b0;
      stop_d            <= 1'b0;
      snooze_d          <= 1'b0;
      bus.sound_alarm   <= 1'b0;
      bus.snooze_active <= 1'b0;
      bus.alarm_missed  <= 1'b0;
    end else begin
      state_q           <= state_d;
      sec_cnt_q         <= sec_cnt_d;
      snooze_cnt_q      <= snooze_cnt_d;
      match_d           <= match;
      stop_d            <= bus.stop_button;
      snooze_d          <= bus.snooze_button;
      bus.sound_alarm   <= (state_d == RINGING);
      bus.snooze_active <= (state_d == SNOOZING);
      bus.alarm_missed  <= missed_d;
    end
  end

  // Snooze count is a register; expose it directly.
  assign bus.snooze_count = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with short ring/snooze periods.
module tb_alarm_ring_ctrl;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .RING_SEC  (4),
    .SNOOZE_SEC(3),
    .MAX_SNOOZE(3),
    .CNT_W     (9)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its expected value.
  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may be changed and outputs sampled afterwards.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.one_second = 1'b1;
      step();
      bus.one_second = 1'b0;
    end
  endtask

  task automatic press_snooze();
    bus.snooze_button = 1'b1;
    step();
    bus.snooze_button = 1'b0;
    step();
  endtask

  task automatic press_stop();
    bus.stop_button = 1'b1;
    step();
    bus.stop_button = 1'b0;
  endtask

  // Produce a fresh rising edge of the alarm match.
  task automatic new_match();
    bus.current_time = 16'h0731;
    step();
    bus.current_time = 16'h0730;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset              = 1'b1;
    bus.one_second     = 1'b0;
    bus.alarm_enable   = 1'b1;
    bus.alarm_time     = 16'h0730;
    bus.current_time   = 16'h0729;
    bus.stop_button    = 1'b0;
    bus.snooze_button  = 1'b0;
    step();
    step();
    check_eq("rst_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("rst_snooze", 16'(bus.snooze_active), 16'd0);
    check_eq("rst_count",  16'(bus.snooze_count), 16'd0);
    check_eq("rst_missed", 16'(bus.alarm_missed), 16'd0);
    reset = 1'b0;
    step();
    check_eq("pre_match_sound", 16'(bus.sound_alarm), 16'd0);

    // Match edge rings, then times out after 4 ticks.
    bus.current_time = 16'h0730;
    step();
    check_eq("ring_start", 16'(bus.sound_alarm), 16'd1);
    ticks(3);
    check_eq("ring_3ticks", 16'(bus.sound_alarm), 16'd1);
    check_eq("ring_no_missed", 16'(bus.alarm_missed), 16'd0);
    ticks(1);
    check_eq("timeout_sound", 16'(bus.sound_alarm), 16'd0);
    check_eq("timeout_missed", 16'(bus.alarm_missed), 16'd1);
    step();
    check_eq("missed_one_cycle", 16'(bus.alarm_missed), 16'd0);
    step();
    step();
    check_eq("held_match_no_rering", 16'(bus.sound_alarm), 16'd0);

    // Snooze up to the limit, extra snooze ignored, stop keeps count.
    new_match();
    check_eq("ring2_start", 16'(bus.sound_alarm), 16'd1);
    for (int s = 1; s <= 3; s++) begin
      press_snooze();
      check_eq("snooze_active", 16'(bus.snooze_active), 16'd1);
      check_eq("snooze_sound",  16'(bus.sound_alarm), 16'd0);
      check_eq("snooze_count",  16'(bus.snooze_count), 16'(s));
      ticks(2);
      check_eq("snooze_still", 16'(bus.snooze_active), 16'd1);
      ticks(1);
      check_eq("rering_sound", 16'(bus.sound_alarm), 16'd1);
      check_eq("rering_count", 16'(bus.snooze_count), 16'(s));
    end
    press_snooze();
    check_eq("snooze4_sound",  16'(bus.sound_alarm), 16'd1);
    check_eq("snooze4_active", 16'(bus.snooze_active), 16'd0);
    check_eq("snooze4_count",  16'(bus.snooze_count), 16'd3);
    press_stop();
    check_eq("stop_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("stop_missed", 16'(bus.alarm_missed), 16'd0);
    check_eq("stop_count_held", 16'(bus.snooze_count), 16'd3);

    // Stop and snooze together: stop wins; held match does not re-ring.
    new_match();
    check_eq("ring3_count_clr", 16'(bus.snooze_count), 16'd0);
    press_snooze();
    ticks(3);
    check_eq("ring3_resume", 16'(bus.sound_alarm), 16'd1);
    bus.stop_button   = 1'b1;
    bus.snooze_button = 1'b1;
    step();
    bus.stop_button   = 1'b0;
    bus.snooze_button = 1'b0;
    check_eq("both_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("both_snooze", 16'(bus.snooze_active), 16'd0);
    check_eq("both_count",  16'(bus.snooze_count), 16'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_no_rering", 16'(bus.sound_alarm), 16'd0);
    end

    // Held snooze across expiry does not snooze again until re-pressed.
    new_match();
    bus.snooze_button = 1'b1;
    step();
    check_eq("held_snz_active", 16'(bus.snooze_active), 16'd1);
    ticks(3);
    check_eq("held_snz_resume", 16'(bus.sound_alarm), 16'd1);
    step();
    step();
    check_eq("held_snz_ringing", 16'(bus.sound_alarm), 16'd1);
    check_eq("held_snz_count",   16'(bus.snooze_count), 16'd1);
    bus.snooze_button = 1'b0;
    step();
    bus.snooze_button = 1'b1;
    step();
    bus.snooze_button = 1'b0;
    check_eq("repress_active", 16'(bus.snooze_active), 16'd1);
    check_eq("repress_count",  16'(bus.snooze_count), 16'd2);
    press_stop();

    // Stop and timeout in the same cycle: idle without a missed pulse.
    new_match();
    ticks(3);
    bus.stop_button = 1'b1;
    bus.one_second  = 1'b1;
    step();
    bus.stop_button = 1'b0;
    bus.one_second  = 1'b0;
    check_eq("stop_to_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("stop_to_missed", 16'(bus.alarm_missed), 16'd0);

    // Snooze and timeout in the same cycle: snooze wins.
    new_match();
    ticks(3);
    bus.snooze_button = 1'b1;
    bus.one_second    = 1'b1;
    step();
    bus.snooze_button = 1'b0;
    bus.one_second    = 1'b0;
    check_eq("snz_to_active", 16'(bus.snooze_active), 16'd1);
    check_eq("snz_to_missed", 16'(bus.alarm_missed), 16'd0);

    // Reset mid-snooze with match true, then ring again after release.
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_rst_snooze", 16'(bus.snooze_active), 16'd0);
    check_eq("async_rst_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("async_rst_count",  16'(bus.snooze_count), 16'd0);
    step();
    reset = 1'b0;
    step();
    check_eq("post_rst_sound", 16'(bus.sound_alarm), 16'd1);
    check_eq("post_rst_count", 16'(bus.snooze_count), 16'd0);

    // Dropping enable mid-ring goes idle with no missed pulse.
    bus.alarm_enable = 1'b0;
    step();
    check_eq("disable_sound",  16'(bus.sound_alarm), 16'd0);
    check_eq("disable_missed", 16'(bus.alarm_missed), 16'd0);
    bus.alarm_enable = 1'b1;
    step();
    check_eq("reenable_rering", 16'(bus.sound_alarm), 16'd1);
    press_stop();
    check_eq("final_idle", 16'(bus.sound_alarm), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
